// File: rtl/mant_norm.sv
// Two-stage normalizer for lane-packed posit adder sums: stage 1 counts leading zeros, stage 2 shifts.
// Optional accepted-result counter (stat_cnt) is built only when MANT_NORM_STAT_EN is defined.
module mant_norm #(
   parameter int LZW    = 6,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [67:0]       mant_pl,
   input  logic [1:0]        in_pre,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [67:0]       mant_nm,
   output logic [4*LZW-1:0]  lzc,
   output logic [3:0]        zero,
   output logic [1:0]        pre_out
`ifdef MANT_NORM_STAT_EN
   ,
   output logic [STAT_W-1:0] stat_cnt
`endif
);

   logic              s1_v;
   logic              s1_adv;
   logic [67:0]       s1_data;
   logic [1:0]        s1_pre;
   logic [4*LZW-1:0]  s1_lzc;
   logic [3:0]        s1_zero;

   logic [1:0]        pre_eff;
   logic [67:0]       data_in;
   logic [4*LZW-1:0]  lzc_in;
   logic [3:0]        zero_in;
   logic [67:0]       shift_d;

   // Leading zeros within the low w bits of v; an all-zero lane reports 0.
   function automatic logic [LZW-1:0] lz_count(input logic [56:0] v, input int w);
      logic [LZW-1:0] n;
      logic           hit;
      n   = '0;
      hit = 1'b0;
      for (int i = 56; i >= 0; i--) begin
         if (i < w && !hit) begin
            if (v[i]) hit = 1'b1;
            else      n   = n + 1'b1;
         end
      end
      return hit ? n : '0;
   endfunction

   assign s1_adv   = !out_valid | out_ready;
   assign in_ready = !s1_v | s1_adv;

   // Stage 1 front end: per-lane LZC and zero detect; in 1x57 mode the junk above bit 56 is dropped.
   always_comb begin
      pre_eff = (in_pre == 2'b11) ? 2'b10 : in_pre;
      data_in = mant_pl;
      lzc_in  = '0;
      zero_in = '0;
      case (pre_eff)
         2'b00: begin
            for (int i = 0; i < 4; i++) begin
               lzc_in[LZW*i +: LZW] = lz_count({40'b0, mant_pl[17*i +: 17]}, 17);
               zero_in[i]           = (mant_pl[17*i +: 17] == 17'd0);
            end
         end
         2'b01: begin
            for (int i = 0; i < 2; i++) begin
               lzc_in[LZW*i +: LZW] = lz_count({23'b0, mant_pl[34*i +: 34]}, 34);
               zero_in[i]           = (mant_pl[34*i +: 34] == 34'd0);
            end
         end
         default: begin
            data_in           = {11'b0, mant_pl[56:0]};
            lzc_in[LZW-1:0]   = lz_count(mant_pl[56:0], 57);
            zero_in[0]        = (mant_pl[56:0] == 57'd0);
         end
      endcase
   end

   // Stage 2 barrel shift; each lane shifts independently and truncates to its own width.
   always_comb begin
      shift_d = '0;
      case (s1_pre)
         2'b00: begin
            for (int i = 0; i < 4; i++)
               shift_d[17*i +: 17] = s1_data[17*i +: 17] << s1_lzc[LZW*i +: LZW];
         end
         2'b01: begin
            for (int i = 0; i < 2; i++)
               shift_d[34*i +: 34] = s1_data[34*i +: 34] << s1_lzc[LZW*i +: LZW];
         end
         default: begin
            shift_d[56:0] = s1_data[56:0] << s1_lzc[LZW-1:0];
         end
      endcase
   end

   // Elastic pipeline registers: S1 refills whenever S2 can take its content.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v      <= 1'b0;
         s1_data   <= '0;
         s1_pre    <= '0;
         s1_lzc    <= '0;
         s1_zero   <= '0;
         out_valid <= 1'b0;
         mant_nm   <= '0;
         lzc       <= '0;
         zero      <= '0;
         pre_out   <= '0;
      end else begin
         if (in_ready) begin
            s1_v <= in_valid;
            if (in_valid) begin
               s1_data <= data_in;
               s1_pre  <= pre_eff;
               s1_lzc  <= lzc_in;
               s1_zero <= zero_in;
            end
         end
         if (s1_adv) begin
            out_valid <= s1_v;
            if (s1_v) begin
               mant_nm <= shift_d;
               lzc     <= s1_lzc;
               zero    <= s1_zero;
               pre_out <= s1_pre;
            end
         end
      end
   end

`ifdef MANT_NORM_STAT_EN
   // Saturating count of results taken by the consumer.
   always_ff @(posedge clk) begin
      if (!rst_n)
         stat_cnt <= '0;
      else if (out_valid && out_ready && stat_cnt != {STAT_W{1'b1}})
         stat_cnt <= stat_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_mant_norm.sv
// Scoreboard bench for mant_norm: driver pushes expectations from an arithmetic reference model,
// a free-running monitor compares every presented result.
module tb_mant_norm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [67:0] mant_pl;
   logic [1:0]  in_pre;
   logic        out_valid;
   logic        out_ready;
   logic [67:0] mant_nm;
   logic [23:0] lzc;
   logic [3:0]  zero;
   logic [1:0]  pre_out;
`ifdef MANT_NORM_STAT_EN
   logic [15:0] stat_cnt;
`endif

   typedef struct {
      logic [67:0] mant;
      logic [23:0] lzc;
      logic [3:0]  zero;
      logic [1:0]  pre;
      bit          lat;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   stat_exp = 0;
   int   rdy_mode = 0;
   bit   mon_en = 1'b0;

   mant_norm #(.LZW(6), .STAT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .mant_pl(mant_pl), .in_pre(in_pre),
      .out_valid(out_valid), .out_ready(out_ready),
      .mant_nm(mant_nm), .lzc(lzc), .zero(zero), .pre_out(pre_out)
`ifdef MANT_NORM_STAT_EN
      , .stat_cnt(stat_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // out_ready: 0 = always high, 1 = always low, 2 = random with 75% high
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (rdy_mode == 0)      out_ready = 1'b1;
         else if (rdy_mode == 1) out_ready = 1'b0;
         else                    out_ready = ($urandom % 4) != 0;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got running, want finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: shift each lane up by doubling until its top bit is set.
   function automatic exp_t model(input logic [67:0] d, input logic [1:0] p, input bit lat);
      exp_t        e;
      int          w, nl, n;
      logic [67:0] mask, lanem;
      logic [63:0] x, top;
      e.mant = '0; e.lzc = '0; e.zero = '0; e.lat = lat; e.cyc = 0;
      e.pre  = (p == 2'b11) ? 2'b10 : p;
      w      = (e.pre == 2'b00) ? 17 : (e.pre == 2'b01) ? 34 : 57;
      nl     = 68 / w;
      mask   = (68'd1 << w) - 68'd1;
      top    = 64'd1 << (w - 1);
      for (int i = 0; i < nl; i++) begin
         lanem = (d >> (w * i)) & mask;
         x     = lanem[63:0];
         n     = 0;
         if (x == 64'd0) e.zero[i] = 1'b1;
         else while (x < top) begin
            x = x * 2;
            n++;
         end
         e.mant = e.mant | ({4'b0, x} << (w * i));
         e.lzc  = e.lzc | (24'(n) << (6 * i));
      end
      return e;
   endfunction

   function automatic logic [67:0] rand_data(input logic [1:0] p);
      logic [95:0] big;
      logic [67:0] d, mask;
      logic [63:0] r;
      int          w, nl, k;
      big = {$urandom, $urandom, $urandom};
      d   = big[67:0];
      w   = (p == 2'b00) ? 17 : (p == 2'b01) ? 34 : 57;
      nl  = 68 / w;
      mask = (68'd1 << w) - 68'd1;
      for (int i = 0; i < nl; i++) begin
         r = {$urandom, $urandom};
         k = $urandom % 8;
         if (k == 0)      r = 64'd0;
         else if (k != 1) r = (r & mask[63:0]) >> ($urandom % (w + 1));
         r = r & mask[63:0];
         d = (d & ~(mask << (w * i))) | ({4'b0, r} << (w * i));
      end
      return d;
   endfunction

   task automatic checkOutput(input exp_t e);
      chk("mant_nm", mant_nm, e.mant);
      chk("lzc", {44'b0, lzc}, {44'b0, e.lzc});
      chk("zero", {64'b0, zero}, {64'b0, e.zero});
      chk("pre_out", {66'b0, pre_out}, {66'b0, e.pre});
      if (e.lat) chk("latency", 68'(cyc - e.cyc), 68'd2);
   endtask

   task automatic checkResetState();
      chk("rst_out_valid", {67'b0, out_valid}, 68'd0);
      chk("rst_mant_nm", mant_nm, 68'd0);
      chk("rst_lzc", {44'b0, lzc}, 68'd0);
      chk("rst_zero", {64'b0, zero}, 68'd0);
      chk("rst_pre_out", {66'b0, pre_out}, 68'd0);
      chk("rst_in_ready", {67'b0, in_ready}, 68'd1);
`ifdef MANT_NORM_STAT_EN
      chk("rst_stat_cnt", {52'b0, stat_cnt}, 68'd0);
`endif
   endtask

   // Monitor: compare every presented result against the oldest expectation; pop on transfer.
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
`ifdef MANT_NORM_STAT_EN
         chk("stat_cnt", {52'b0, stat_cnt}, 68'(stat_exp));
`endif
         if (out_valid) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("[TB] FAIL unexpected_output: got %0h, want no output", mant_nm);
            end else begin
               checkOutput(sb[0]);
               if (out_ready) begin
                  void'(sb.pop_front());
                  if (stat_exp < 65535) stat_exp++;
               end
            end
         end
      end
   end

   task automatic waitAccept(input exp_t e);
      bit ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) begin
            e.cyc = cyc;
            sb.push_back(e);
            ok = 1'b1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL accept_timeout: got in_ready=0, want 1");
      end
   endtask

   task automatic applyStimulus(input logic [67:0] d, input logic [1:0] p, input exp_t e);
      @(posedge clk);
      #1;
      mant_pl  = d;
      in_pre   = p;
      in_valid = 1'b1;
      waitAccept(e);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      rdy_mode = 0;
      for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL drain: got %0d pending, want 0", sb.size());
      end
   endtask

   initial begin
      exp_t        e;
      logic [67:0] d;
      logic [1:0]  p;
      rst_n = 1'b0; in_valid = 1'b0; mant_pl = '0; in_pre = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkResetState();
      mon_en = 1'b1;

      // T1..T3 directed vectors with hand-derived expectations
      e = '{mant: {17'h1E000, 17'h0, 17'h10000, 17'h10000}, lzc: {6'd5, 6'd0, 6'd16, 6'd0},
            zero: 4'b0100, pre: 2'b00, lat: 1'b1, cyc: 0};
      applyStimulus({17'h00F00, 17'h0, 17'h00001, 17'h10000}, 2'b00, e);
      e = '{mant: {34'h200000000, 34'h300000000}, lzc: {18'd0, 6'd32},
            zero: 4'b0000, pre: 2'b01, lat: 1'b1, cyc: 0};
      applyStimulus({34'h200000000, 34'h000000003}, 2'b01, e);
      e = '{mant: 68'h0_0100_0000_0000_0000, lzc: {18'd0, 6'd56},
            zero: 4'b0000, pre: 2'b10, lat: 1'b1, cyc: 0};
      applyStimulus(68'hF_FE00_0000_0000_0001, 2'b10, e);
      applyStimulus(68'hF_FE00_0000_0000_0001, 2'b11, e);
      e = '{mant: 68'd0, lzc: 24'd0, zero: 4'b1111, pre: 2'b00, lat: 1'b1, cyc: 0};
      applyStimulus(68'd0, 2'b00, e);

      // T4 back-to-back mixed precisions, latency checked on each
      for (int i = 0; i < 12; i++) begin
         p = 2'(i % 3);
         d = rand_data(p);
         applyStimulus(d, p, model(d, p, 1'b1));
      end
      idle();
      drain();

      // T4 cont. stall: two accepts fill the pipe, then in_ready must stay low
      rdy_mode = 1;
      for (int i = 0; i < 2; i++) begin
         d = rand_data(2'b01);
         applyStimulus(d, 2'b01, model(d, 2'b01, 1'b0));
      end
      @(posedge clk);
      #1;
      d = rand_data(2'b00);
      mant_pl = d; in_pre = 2'b00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready", {67'b0, in_ready}, 68'd0);
      end
      rdy_mode = 0;
      waitAccept(model(d, 2'b00, 1'b0));
      idle();
      drain();

      // T5 reset with the pipe full
      rdy_mode = 1;
      for (int i = 0; i < 2; i++) begin
         d = rand_data(2'b10);
         applyStimulus(d, 2'b10, model(d, 2'b10, 1'b0));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mon_en   = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      stat_exp = 0;
      @(negedge clk);
      checkResetState();
      mon_en = 1'b1;

      // randomized traffic with random backpressure and input gaps
      rdy_mode = 2;
      for (int i = 0; i < 400; i++) begin
         p = 2'($urandom % 4);
         d = rand_data(p);
         if ($urandom % 4 == 0) idle();
         applyStimulus(d, p, model(d, p, 1'b0));
      end
      idle();
      drain();
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
